mult_arbiter: RTL and testbench

- Shares one signed 16x16 hardware multiplier between N requesters, e.g. the I/Q demodulation and filter stages of the lock-in datapath.
- Accepts at most one operand pair per cycle, chosen by round-robin grant.
- Drives the multiplier's operand inputs from registers and carries a requester tag alongside the multiplier pipeline.
- Returns each product with the ID of the requester that issued it. Results are never back-pressured; the multiplier runs with CE tied high.

---
 rtl/mult_arb_pkg.sv | 20 ++
 rtl/mult_arbiter_rr_arbiter.sv | 56 +++++
 rtl/mult_arbiter.sv | 74 +++++++
 tb/tb_mult_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared widths, ID-width helper and tag type for mult_arbiter.
`default_nettype none
package mult_arb_pkg;
  localparam int OP_W    = 16;
  localparam int PROD_W  = 32;
  localparam int MAX_REQ = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sized for the largest supported requester count; narrower IDs are zero-extended.
  localparam int TAG_ID_W = id_width(MAX_REQ);

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage
`default_nettype wire

// File: rtl/mult_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant with wrap-around pointer.
// Optional macro MULT_ARBITER_PRIO_EN gives requester 0 strict priority.
`default_nettype none
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);
  logic [ID_W-1:0] ptr;
  logic            prio_hit;
  int              idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    prio_hit  = 1'b0;
    idx       = 0;
    if (rst_n && en) begin
      // Walk downward so the nearest valid requester above the pointer wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (valid[idx]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(idx);
          grant     = N_REQ'(1) << idx;
        end
      end
`ifdef MULT_ARBITER_PRIO_EN
      if (valid[0]) begin
        grant_vld = 1'b1;
        grant_id  = '0;
        grant     = N_REQ'(1);
        prio_hit  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_vld && !prio_hit) begin
      ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one signed 16x16 multiplier between N_REQ requesters, tagging each product.
// Optional macro MULT_ARBITER_PRIO_EN: requester 0 gets strict priority.
`default_nettype none
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MULT_LATENCY = 1,
  parameter int ID_W         = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_a,
  input  logic [N_REQ*OP_W-1:0]   req_b,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]       mul_p,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [PROD_W-1:0]       res_data,
  output logic                    busy
);
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gid;
  logic             gvld;
  tag_t             tags [0:MULT_LATENCY];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .valid     (req_valid),
    .grant     (grant),
    .grant_id  (gid),
    .grant_vld (gvld)
  );

  assign req_ready = grant;

  // Tag stage k lines up with the multiplier's internal stage k; the output stage
  // captures mul_p together with the last tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      for (int s = 0; s <= MULT_LATENCY; s++) tags[s] <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      if (gvld) begin
        mul_a <= req_a[int'(gid)*OP_W +: OP_W];
        mul_b <= req_b[int'(gid)*OP_W +: OP_W];
      end
      tags[0] <= '{vld: gvld, id: TAG_ID_W'(gid)};
      for (int s = 1; s <= MULT_LATENCY; s++) tags[s] <= tags[s-1];
      res_valid <= tags[MULT_LATENCY].vld;
      res_id    <= ID_W'(tags[MULT_LATENCY].id);
      res_data  <= mul_p;
    end
  end

  always_comb begin
    busy = res_valid;
    for (int s = 0; s <= MULT_LATENCY; s++) busy = busy | tags[s].vld;
  end
endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: randomized self-checking bench with a queue-based reference model.
`default_nettype none
module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst_n, en;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*16-1:0]   req_a, req_b;
  logic [15:0]       mul_a, mul_b;
  logic [31:0]       mul_p;
  logic              res_valid, busy;
  logic [IW-1:0]     res_id;
  logic [31:0]       res_data;
  logic [15:0]       opa [N];
  logic [15:0]       opb [N];

  mult_arbiter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = opa[i];
      req_b[16*i +: 16] = opb[i];
    end
  end

  // External multiplier: LAT-cycle registered signed product.
  logic [31:0] mpipe [LAT];
  always_ff @(posedge clk) begin
    mpipe[0] <= 32'($signed(mul_a) * $signed(mul_b));
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] p;
    int          due;
  } exp_t;

  exp_t q[$];
  int ptr_m = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [N-1:0]  obs_ready, exp_ready;
  logic          obs_rv, exp_rv, obs_busy, exp_busy;
  logic [IW-1:0] obs_id, exp_id;
  logic [31:0]   obs_data, exp_data;

  function automatic int model_grant();
    if (!rst_n || !en) return -1;
`ifdef MULT_ARBITER_PRIO_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (req_valid[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // Advance one clock with inputs already driven; fill obs_* and exp_*.
  task automatic tick();
    int g;
    logic [31:0] p;
    g = model_grant();
    #1;
    obs_ready = req_ready;
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      p = 32'(int'($signed(opa[g])) * int'($signed(opb[g])));
      q.push_back('{g, p, cyc + 1 + LAT});
`ifdef MULT_ARBITER_PRIO_EN
      if (g != 0) ptr_m = (g + 1) % N;
`else
      ptr_m = (g + 1) % N;
`endif
    end
    @(negedge clk);
    obs_rv = res_valid; obs_id = res_id; obs_data = res_data; obs_busy = busy;
    exp_rv = 1'b0; exp_id = '0; exp_data = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv = 1'b1; exp_id = IW'(q[0].id); exp_data = q[0].p;
      void'(q.pop_front());
    end
    exp_busy = exp_rv || (q.size() > 0);
  endtask

  task automatic model_reset();
    q.delete();
    ptr_m = 0;
  endtask

  task automatic test_reset();
    req_valid = '1; en = 1'b1;
    for (int i = 0; i < N; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 2;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL reset_pre_ready got=%b exp=%b", obs_ready, exp_ready); end
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin
        errors++; $display("FAIL reset_pre_result got=%b/%0d/%h exp=%b/%0d/%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data);
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks += 3;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    @(negedge clk);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    checks += 2;
    if (obs_rv !== 1'b0) begin errors++; $display("FAIL reset_post_valid got=%b exp=0", obs_rv); end
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_post_busy got=%b exp=0", obs_busy); end
    req_valid = '1;
    tick();
    checks += 1;
    if (obs_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", obs_ready); end
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_single();
    logic [15:0] av [2];
    logic [31:0] pv [2];
    av[0] = 16'h7FFF; av[1] = 16'h8000;
    pv[0] = 32'h3FFF0001; pv[1] = 32'h40000000;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 4; k++) begin
        req_valid = (k == 0) ? 4'b0001 : 4'b0000;
        opa[0] = av[t]; opb[0] = av[t];
        tick();
        checks += 3;
        if (obs_ready !== exp_ready) begin errors++; $display("FAIL single_ready got=%b exp=%b", obs_ready, exp_ready); end
        if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin
          errors++; $display("FAIL single_result got=%b/%0d/%h exp=%b/%0d/%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data);
        end
        if (obs_busy !== exp_busy) begin errors++; $display("FAIL single_busy got=%b exp=%b", obs_busy, exp_busy); end
        if (k == 2) begin
          checks++;
          if (obs_rv !== 1'b1 || obs_id !== 2'd0 || obs_data !== pv[t]) begin
            errors++; $display("FAIL single_latency got=%b/%0d/%h exp=1/0/%h", obs_rv, obs_id, obs_data, pv[t]);
          end
        end
      end
    end
  endtask

  task automatic test_all_valid();
    logic [N-1:0] prev;
    logic [31:0]  want;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'hFFFE; end
    prev = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks += 2;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rotate_ready got=%b exp=%b", obs_ready, exp_ready); end
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin
        errors++; $display("FAIL rotate_result got=%b/%0d/%h exp=%b/%0d/%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data);
      end
      if (k > 0) begin
        checks++;
        if (obs_ready !== {prev[N-2:0], prev[N-1]}) begin
          errors++; $display("FAIL rotate_order got=%b prev=%b", obs_ready, prev);
        end
      end
      if (k >= 2) begin
        want = 32'(-2 * (int'(obs_id) + 1));
        checks++;
        if (obs_rv !== 1'b1 || obs_data !== want) begin
          errors++; $display("FAIL rotate_stream got=%b/%h exp=1/%h", obs_rv, obs_data, want);
        end
      end
      prev = obs_ready;
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_en_drop();
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      en = !(k >= 4 && k < 7);
      for (int i = 0; i < N; i++)
        if (k == 0 || obs_ready[i]) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
      tick();
      checks += 3;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL endrop_ready got=%b exp=%b", obs_ready, exp_ready); end
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin
        errors++; $display("FAIL endrop_result got=%b/%0d/%h exp=%b/%0d/%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data);
      end
      if (obs_busy !== exp_busy) begin errors++; $display("FAIL endrop_busy got=%b exp=%b", obs_busy, exp_busy); end
      if (!en) begin
        checks++;
        if (obs_ready !== '0) begin errors++; $display("FAIL endrop_noready got=%b exp=0", obs_ready); end
      end
    end
    en = 1'b1; req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_reset_inflight();
    req_valid = 4'b0011;
    for (int i = 0; i < N; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL inflight_busy got=%b exp=0", busy); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL inflight_valid got=%b exp=0", res_valid); end
    @(negedge clk);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs_rv !== 1'b0 || obs_busy !== 1'b0) begin
        errors++; $display("FAIL inflight_discard got=%b/%b exp=0/0", obs_rv, obs_busy);
      end
    end
  endtask

  task automatic test_prio();
    logic [N-1:0] prev;
    req_valid = 4'b0101;
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin opa[i] = 16'($urandom); opb[i] = 16'($urandom); end
      tick();
      checks += 3;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL prio_ready got=%b exp=%b", obs_ready, exp_ready); end
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin
        errors++; $display("FAIL prio_result got=%b/%0d/%h exp=%b/%0d/%h", obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data);
      end
`ifdef MULT_ARBITER_PRIO_EN
      if (obs_ready !== 4'b0001) begin errors++; $display("FAIL prio_order got=%b exp=0001", obs_ready); end
`else
      if ((k == 0 && obs_ready !== 4'b0001 && obs_ready !== 4'b0100) ||
          (k > 0 && obs_ready !== ((prev == 4'b0001) ? 4'b0100 : 4'b0001))) begin
        errors++; $display("FAIL prio_order got=%b prev=%b", obs_ready, prev);
      end
`endif
      prev = obs_ready;
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    pend = '0;
    for (int k = 0; k < 200; k++) begin
      en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          opa[i] = 16'($urandom);
          opb[i] = 16'($urandom);
        end
      end
      tick();
      pend = req_valid & ~obs_ready;
      checks += 3;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL random_ready k=%0d got=%b exp=%b", k, obs_ready, exp_ready); end
      if (obs_rv !== exp_rv || (exp_rv && {obs_id, obs_data} !== {exp_id, exp_data})) begin
        errors++; $display("FAIL random_result k=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, obs_rv, obs_id, obs_data, exp_rv, exp_id, exp_data);
      end
      if (obs_busy !== exp_busy) begin errors++; $display("FAIL random_busy k=%0d got=%b exp=%b", k, obs_busy, exp_busy); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_all_valid();
    test_en_drop();
    test_reset_inflight();
    test_prio();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
